// File: rtl/nn_bram_pkg.sv
// Shared constants and FSM encoding for the activation BRAM row reader.
package nn_bram_pkg;

    localparam int unsigned N_ELEM_DEF = 28;    // elements per row
    localparam int unsigned DATA_W_DEF = 8;     // signed int8 activations
    localparam int unsigned ADDR_W_DEF = 11;    // 2048 x 8 in one 18Kb macro
    localparam int unsigned BRAM_DEPTH = 2048;

    // BRAM read latency encoding: output register off / on
    localparam int unsigned RD_LAT_NO_REG = 1;
    localparam int unsigned RD_LAT_DO_REG = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/bram_rd_capture.sv
// Capture side of the row reader: delays each request tag by the BRAM read
// latency, writes returning data into the shadow row, flags the final slot.
// Optional macro BRAM_ROW_READER_RELU_EN clamps negative elements to zero.
module bram_rd_capture
    import nn_bram_pkg::*;
#(
    parameter int unsigned N_ELEM = N_ELEM_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = RD_LAT_NO_REG,
    parameter int unsigned CNT_W  = $clog2(N_ELEM)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_req_vld,
    input  logic [CNT_W-1:0]           i_req_idx,
    input  logic [DATA_W-1:0]          i_mem_dout,
    output logic                       o_cap_last,
    output logic [N_ELEM*DATA_W-1:0]   o_row_next
);

    logic [RD_LAT-1:0]        r_vld_pipe;
    logic [CNT_W-1:0]         r_idx_pipe [RD_LAT];
    logic [N_ELEM*DATA_W-1:0] r_shadow;
    logic                     w_cap_vld;
    logic [CNT_W-1:0]         w_cap_idx;
    logic [DATA_W-1:0]        w_elem;

    assign w_cap_vld  = r_vld_pipe[RD_LAT-1];
    assign w_cap_idx  = r_idx_pipe[RD_LAT-1];
    assign o_cap_last = w_cap_vld && (w_cap_idx == CNT_W'(N_ELEM - 1));

`ifdef BRAM_ROW_READER_RELU_EN
    assign w_elem = i_mem_dout[DATA_W-1] ? '0 : i_mem_dout;
`else
    assign w_elem = i_mem_dout;
`endif

    // Delay each request's valid/slot tag so it lines up with its returning data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_idx_pipe[i] <= '0;
            end
        end else begin
            r_vld_pipe[0] <= i_req_vld;
            r_idx_pipe[0] <= i_req_idx;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_idx_pipe[i] <= r_idx_pipe[i-1];
            end
        end
    end

    // Shadow row with the element arriving this cycle merged in; the top latches
    // this on the final capture so the last element is part of the atomic update
    always_comb begin
        o_row_next = r_shadow;
        if (w_cap_vld) begin
            o_row_next[w_cap_idx*DATA_W +: DATA_W] = w_elem;
        end
    end

    // Shadow register file
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow <= '0;
        end else begin
            r_shadow <= o_row_next;
        end
    end

endmodule

// File: rtl/bram_row_reader.sv
// Fetches one row of N_ELEM signed activations from the activation BRAM and
// presents it as a flat parallel bus, updated atomically with the done pulse.
// Optional macro BRAM_ROW_READER_RELU_EN (in bram_rd_capture) clamps negatives.
module bram_row_reader
    import nn_bram_pkg::*;
#(
    parameter int unsigned N_ELEM = N_ELEM_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned RD_LAT = RD_LAT_NO_REG
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [ADDR_W-1:0]          i_base_addr,
    output logic [ADDR_W-1:0]          o_mem_addr,
    output logic                       o_mem_en,
    input  logic [DATA_W-1:0]          i_mem_dout,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_range_err,
    output logic [N_ELEM*DATA_W-1:0]   o_row_data
);

    localparam int unsigned       CNT_W    = $clog2(N_ELEM);
    localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'(2**ADDR_W - N_ELEM);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_ELEM - 1);

    rd_state_e                r_state, w_state_nxt;
    logic [ADDR_W-1:0]        r_mem_addr, w_addr_nxt;
    logic                     r_mem_en, w_en_nxt;
    logic                     r_busy, w_busy_nxt;
    logic                     r_done, w_done_nxt;
    logic                     r_range_err, w_err_nxt;
    logic [CNT_W-1:0]         r_issue_cnt, w_cnt_nxt;
    logic [N_ELEM*DATA_W-1:0] r_row_data, w_row_nxt;
    logic                     w_cap_last;
    logic [N_ELEM*DATA_W-1:0] w_row_next;

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_en    = r_mem_en;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_range_err = r_range_err;
    assign o_row_data  = r_row_data;

    bram_rd_capture #(
        .N_ELEM (N_ELEM),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .CNT_W  (CNT_W)
    ) u_capture (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req_vld  (r_mem_en),
        .i_req_idx  (r_issue_cnt),
        .i_mem_dout (i_mem_dout),
        .o_cap_last (w_cap_last),
        .o_row_next (w_row_next)
    );

    // Next-state and register updates for the issue/drain sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_mem_addr;
        w_en_nxt    = r_mem_en;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_issue_cnt;
        w_row_nxt   = r_row_data;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    // Rows never wrap past the top of the BRAM
                    if (i_base_addr > MAX_BASE) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = StIssue;
                        w_addr_nxt  = i_base_addr;
                        w_en_nxt    = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            StIssue: begin
                if (r_issue_cnt == LAST_IDX) begin
                    w_en_nxt    = 1'b0;
                    w_state_nxt = StDrain;
                end else begin
                    w_addr_nxt = r_mem_addr + 1'b1;
                    w_cnt_nxt  = r_issue_cnt + 1'b1;
                end
            end
            StDrain: begin
                if (w_cap_last) begin
                    w_row_nxt   = w_row_next;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_mem_addr  <= '0;
            r_mem_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_range_err <= 1'b0;
            r_issue_cnt <= '0;
            r_row_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_en    <= w_en_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_range_err <= w_err_nxt;
            r_issue_cnt <= w_cnt_nxt;
            r_row_data  <= w_row_nxt;
        end
    end

endmodule

// File: tb/tb_bram_row_reader.sv
// Bench for bram_row_reader: two instances (read latency 1 and 2) share one
// BRAM image; rows are predicted straight from the memory array.
module tb_bram_row_reader;

    localparam int N  = 28;
    localparam int DW = 8;
    localparam int AW = 11;
    localparam int RW = N * DW;

    logic                 clk   = 1'b0;
    logic                 rst   = 1'b1;
    logic [1:0]           start = '0;
    logic [1:0][AW-1:0]   base  = '0;
    logic [1:0][AW-1:0]   maddr;
    logic [1:0]           men, busy, done, rerr;
    logic [1:0][DW-1:0]   mdout;
    logic [1:0][RW-1:0]   row;

    logic [DW-1:0]        mem [2048];
    logic [DW-1:0]        pat [4] = '{8'h80, 8'hFF, 8'h7F, 8'h01};

    int                   n_checks = 0;
    int                   n_pass   = 0;
    int                   en_cnt   [2];
    int                   done_cnt [2];
    logic [AW-1:0]        exp_base [2];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] q1 = '0;
        logic [DW-1:0] q2 = '0;

        bram_row_reader #(
            .N_ELEM (N),
            .DATA_W (DW),
            .ADDR_W (AW),
            .RD_LAT (g + 1)
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_start     (start[g]),
            .i_base_addr (base[g]),
            .o_mem_addr  (maddr[g]),
            .o_mem_en    (men[g]),
            .i_mem_dout  (mdout[g]),
            .o_busy      (busy[g]),
            .o_done      (done[g]),
            .o_range_err (rerr[g]),
            .o_row_data  (row[g])
        );

        // BRAM: registered read, optional output register
        always @(posedge clk) begin
            if (men[g]) q1 <= mem[maddr[g]];
            q2 <= q1;
        end
        assign mdout[g] = (g == 0) ? q1 : q2;

        // Every request must be the next consecutive address of the row
        always @(negedge clk) begin
            if (!rst) begin
                if (men[g]) begin
                    check("mem_addr", RW'(maddr[g]), RW'(exp_base[g] + AW'(en_cnt[g])));
                    en_cnt[g]++;
                end
                if (done[g]) done_cnt[g]++;
            end
        end
    end

    function automatic logic [RW-1:0] exp_row(input logic [AW-1:0] b);
        logic [RW-1:0] r;
        logic [DW-1:0] v;
        r = '0;
        for (int k = 0; k < N; k++) begin
            v = mem[b + AW'(k)];
`ifdef BRAM_ROW_READER_RELU_EN
            if (v[DW-1]) v = '0;
`endif
            r[k*DW +: DW] = v;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start to both instances; returns just after the sampling edge (edge 0)
    task automatic launch(input logic [AW-1:0] b);
        for (int g = 0; g < 2; g++) begin
            exp_base[g] = b;
            en_cnt[g]   = 0;
            done_cnt[g] = 0;
        end
        base  = {b, b};
        start = 2'b11;
        tick();
        start = '0;
    endtask

    task automatic read_row(input logic [AW-1:0] b, input bit poke);
        logic [RW-1:0] want;
        logic [1:0]    seen;
        int            dedge [2];
        want  = exp_row(b);
        seen  = '0;
        dedge = '{0, 0};
        launch(b);
        check("busy_start", RW'(busy), RW'(2'b11));
        for (int n = 1; n <= 80; n++) begin
            tick();
            start = '0;
            for (int g = 0; g < 2; g++) begin
                if (done[g] && !seen[g]) begin
                    seen[g]  = 1'b1;
                    dedge[g] = n;
                    check("row_at_done", row[g], want);
                    check("busy_at_done", RW'(busy[g]), '0);
                    // A start seen while in DONE must be dropped
                    if (poke) begin
                        start[g] = 1'b1;
                        base[g]  = AW'($urandom_range(0, 2020));
                    end
                end
            end
            // A start during ISSUE must be dropped as well
            if (poke && n == 5) start = 2'b11;
            if (seen == 2'b11) break;
        end
        tick();
        start = '0;
        repeat (3) tick();
        check("done_seen", RW'(seen), RW'(2'b11));
        for (int g = 0; g < 2; g++) begin
            // Done is registered on edge N+RD_LAT after the start-sampling edge
            check("done_edge", RW'(dedge[g]), RW'(N + g + 1));
            check("rd_count", RW'(en_cnt[g]), RW'(N));
            check("done_count", RW'(done_cnt[g]), RW'(1));
            check("busy_end", RW'(busy[g]), '0);
            check("row_hold", row[g], want);
        end
    endtask

    initial begin
        logic [1:0][RW-1:0] saved;
        for (int i = 0; i < 2048; i++) mem[i] = DW'($urandom);
        for (int k = 0; k < N; k++) mem[100 + k] = DW'(k);
        for (int k = 0; k < N; k++) mem[300 + k] = pat[k % 4];

        repeat (3) tick();
        check("rst_row", row[0] | row[1], '0);
        check("rst_flags", RW'({men, busy, done, rerr}), '0);
        check("rst_addr", RW'(maddr), '0);
        rst = 1'b0;
        tick();

        read_row(AW'(100), 1'b0);
        read_row(AW'(2020), 1'b0);

        // Request that would run past the top of the BRAM
        saved = row;
        for (int g = 0; g < 2; g++) begin
            exp_base[g] = AW'(2021);
            en_cnt[g]   = 0;
        end
        base  = {AW'(2021), AW'(2021)};
        start = 2'b11;
        tick();
        start = '0;
        check("range_err", RW'(rerr), RW'(2'b11));
        check("busy_rej", RW'(busy), '0);
        tick();
        check("range_err_clr", RW'(rerr), '0);
        repeat (4) tick();
        for (int g = 0; g < 2; g++) begin
            check("rej_reads", RW'(en_cnt[g]), '0);
            check("rej_row", row[g], saved[g]);
        end

        read_row(AW'(300), 1'b0);
        read_row(AW'(500), 1'b1);

        // Reset sampled on edge 15 of a read
        launch(AW'(700));
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_row", row[0] | row[1], '0);
        check("abort_busy", RW'(busy), '0);
        check("abort_done", RW'(done), '0);
        repeat (40) tick();
        for (int g = 0; g < 2; g++) check("abort_no_done", RW'(done_cnt[g]), '0);
        read_row(AW'(700), 1'b0);

        read_row(AW'(0), 1'b0);
        read_row(AW'(28), 1'b0);

        repeat (6) begin
            read_row(AW'($urandom_range(0, 2020)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
